prog_loader: RTL and testbench
==============================

# prog_loader

Parametrised serial image loader for the tiny processor. On `drive`, streams up to `N_SEG` memory segments (instruction, data, …) from an external image store into the processor as one-wire framed packets, then starts execution with a run mode and reports completion. Sits between the FPGA demo top (image ROM, buttons) and the processor's serial load port.

## Interface
- `DATA_W`, 8: bits per memory word
- `ADDR_W`, 4: word address width; each segment holds `2**ADDR_W` words
- `N_SEG`, 2: number of segments; segment s is loaded with mode code s+1
- `MODE_W`, `$clog2(N_SEG+2)`: mode bus width (derived, do not override)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `drive`  in  1  level request: start load; deassert to abort or re-arm
- `seg_en`  in  N_SEG  segment enable mask, sampled on leaving IDLE
- `img_seg`  out  $clog2(N_SEG) (min 1)  image read segment select
- `img_addr`  out  ADDR_W  image read address
- `img_data`  in  DATA_W  image read data, valid one cycle after `img_seg`/`img_addr`
- `done_in`  in  1  processor finished execution
- `mosi_out`  out  1  serial packet bit
- `mode_out`  out  MODE_W  0 idle, s+1 loading segment s, all-ones run
- `done_out`  out  1  load and run sequence complete
- `busy`  out  1  high in any state other than IDLE/FIN

## Operation
- Packet per word, `PKT_W = 1+DATA_W+ADDR_W` bits, sent LSB first: `{frame, data, addr}`; `frame` = 0.
- States: IDLE, SETUP0, SETUP1, SHIFT, GAP, STALL, FIN.
- IDLE: `drive`=1 → latch `seg_en`, select first enabled segment, addr 0 → SETUP0. No enabled segment → STALL.
- SETUP0: `img_seg/img_addr` presented. SETUP1: capture `img_data` into shift register. Both: `mode_out`=s+1, `mosi_out`=0.
- SHIFT: `PKT_W` cycles, one bit per cycle; `mode_out`=s+1 → GAP after bit `PKT_W-1`.
- GAP: one cycle, `mode_out`=0, `mosi_out`=0; addr max → next enabled segment (SETUP0) or STALL; else addr+1 → SETUP0.
- STALL: one cycle, `mode_out`=all-ones → FIN.
- FIN: `done_out`=1; `mode_out`=all-ones until `done_in` seen, then 0 (sticky until IDLE); `drive`=0 → IDLE.
- Abort: `drive`=0 in any SETUP/SHIFT/GAP/STALL state → IDLE next cycle; `mode_out`=0 from that cycle.
- Address wrap: addr counter width ADDR_W; max value ends segment, counter reset to 0.

## Timing
- Reset: state IDLE, `mosi_out`=0, `mode_out`=0, `done_out`=0, `busy`=0, `img_seg`=0, `img_addr`=0, counters 0.
- All outputs registered or decoded from registered state only; no input→output combinational path except none.
- First SETUP0 one cycle after `drive` sampled high in IDLE.
- Per word: `PKT_W+3` cycles (16 at defaults); per segment `2**ADDR_W*(PKT_W+3)`.
- Default full load (both segments): 512 cycles SETUP0→last GAP, then STALL, FIN.
- `done_in` sampled only in FIN; `done_in` high on FIN entry drops `mode_out` to 0 next cycle.
- `seg_en` changes after IDLE are ignored until next load.

## Configuration
- `PROG_LOADER_PARITY_EN`: defined → `frame` bit = even parity over `{data, addr}` (XOR of those bits), still sent last. Undefined → `frame` = 0. Timing, packet length and states unchanged.

## Structure
- `prog_loader_pkg`: state enum `loader_state_t`, `PKT_W` computation function, mode code function `seg_mode(s)` and `RUN_MODE` constant.
- Sub-module `loader_piso`: `PKT_W`-wide parallel-load shift register with bit counter and `last` flag; FSM in `prog_loader` controls load/shift.

## Test plan
- Defaults, `seg_en`=2'b11, image seg0[a]=a+8'h10, seg1[a]=~a → 32 packets, each `{0,data,addr}` LSB first under modes 1 then 2, GAP mode 0 between; STALL mode 3 at cycle 513 after SETUP0.
- `seg_en`=2'b10 → only 16 packets, all mode 2; `img_seg`=1 throughout.
- `seg_en`=2'b00 → IDLE, STALL, FIN; `done_out`=1 two cycles after `drive`.
- `drive` dropped during bit 5 of word 3, seg0 → IDLE next cycle, `mode_out`=0, `busy`=0; reassert → restart at seg0 addr 0.
- FIN with `done_in` pulsed at cycle 20 → `mode_out` 3 then 0 from cycle 21, stays 0; `drive`=0 → IDLE, `done_out`=0.
- `rst` asserted mid-SHIFT (async, between edges) → outputs at reset values immediately; with `PROG_LOADER_PARITY_EN`, data 8'h01 addr 4'h0 → frame bit 1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state type, packet width and mode helpers for the image loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP0,
    SETUP1,
    SHIFT,
    GAP,
    STALL,
    FIN
  } loader_state_t;

  // All-ones run code; users keep the low MODE_W bits
  localparam logic [31:0] RUN_MODE = '1;

  // Packet is {frame, data, addr}
  function automatic int pkt_width(input int data_w, input int addr_w);
    return 1 + data_w + addr_w;
  endfunction

  // Segment s is loaded under mode code s+1 (0 is reserved for idle)
  function automatic int seg_mode(input int s);
    return s + 1;
  endfunction

endpackage

// File: rtl/loader_piso.sv
// rtl/loader_piso.sv - parallel-load, LSB-first shift register with bit counter and last-bit flag
module loader_piso #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout,
  output logic         last
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;

  // Load a new packet or move the next bit down to the output position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {1'b0, sr[W-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dout = sr[0];
  assign last = (cnt == CNT_W'(W - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial image loader FSM; PROG_LOADER_PARITY_EN selects even-parity frame bit
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  parameter  int N_SEG  = 2,
  localparam int MODE_W = $clog2(N_SEG + 2),
  localparam int SEG_W  = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive,
  input  logic [N_SEG-1:0]  seg_en,
  output logic [SEG_W-1:0]  img_seg,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  input  logic              done_in,
  output logic              mosi_out,
  output logic [MODE_W-1:0] mode_out,
  output logic              done_out,
  output logic              busy
);

  localparam int                PKT_W    = pkt_width(DATA_W, ADDR_W);
  localparam logic [MODE_W-1:0] RUN_CODE = RUN_MODE[MODE_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  loader_state_t     state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N_SEG-1:0]  mask_q, mask_d;
  logic              done_seen_q, done_seen_d;

  logic [N_SEG-1:0]  scan_mask;
  int                scan_start;
  logic              scan_found;
  logic [SEG_W-1:0]  scan_idx;

  logic [MODE_W-1:0] seg_code;
  logic              frame_bit;
  logic [PKT_W-1:0]  pkt_word;
  logic              piso_load, piso_shift, piso_dout, piso_last;

  assign img_seg  = seg_q;
  assign img_addr = addr_q;
  assign seg_code = MODE_W'(seg_mode(int'(seg_q)));

`ifdef PROG_LOADER_PARITY_EN
  assign frame_bit = ^{img_data, addr_q};
`else
  assign frame_bit = 1'b0;
`endif

  assign pkt_word = {frame_bit, img_data, addr_q};

  loader_piso #(.W(PKT_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (pkt_word),
    .dout  (piso_dout),
    .last  (piso_last)
  );

  // Lowest enabled segment at or above the scan start (fresh mask in IDLE, latched mask otherwise)
  always_comb begin
    scan_mask  = (state_q == IDLE) ? seg_en : mask_q;
    scan_start = (state_q == IDLE) ? 0 : int'(seg_q) + 1;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = N_SEG - 1; i >= 0; i--) begin
      if (scan_mask[i] && (i >= scan_start)) begin
        scan_found = 1'b1;
        scan_idx   = SEG_W'(i);
      end
    end
  end

  // State, segment/address counters, latched enable mask and done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Next-state logic and outputs decoded from registered state
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    done_seen_d = done_seen_q;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    mode_out    = '0;
    mosi_out    = 1'b0;
    done_out    = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        done_seen_d = 1'b0;
        if (drive) begin
          mask_d = seg_en;
          addr_d = '0;
          if (scan_found) begin
            seg_d   = scan_idx;
            state_d = SETUP0;
          end else begin
            seg_d   = '0;
            state_d = STALL;
          end
        end
      end
      SETUP0: begin
        busy     = 1'b1;
        mode_out = seg_code;
        state_d  = SETUP1;
      end
      SETUP1: begin
        busy      = 1'b1;
        mode_out  = seg_code;
        piso_load = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        mode_out   = seg_code;
        mosi_out   = piso_dout;
        piso_shift = 1'b1;
        if (piso_last) begin
          state_d = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (addr_q == ADDR_MAX) begin
          addr_d = '0;
          if (scan_found) begin
            seg_d   = scan_idx;
            state_d = SETUP0;
          end else begin
            state_d = STALL;
          end
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = SETUP0;
        end
      end
      STALL: begin
        busy     = 1'b1;
        mode_out = RUN_CODE;
        state_d  = FIN;
      end
      FIN: begin
        done_out = 1'b1;
        mode_out = done_seen_q ? '0 : RUN_CODE;
        if (done_in) begin
          done_seen_d = 1'b1;
        end
        if (!drive) begin
          done_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Dropping drive while loading abandons the sequence
    if (busy && !drive) begin
      state_d    = IDLE;
      seg_d      = '0;
      addr_d     = '0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader; honours PROG_LOADER_PARITY_EN
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int N_SEG  = 2;
  localparam int PKT_W  = 1 + DATA_W + ADDR_W;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              drive;
  logic              done_in;
  logic [N_SEG-1:0]  seg_en;
  logic [0:0]        img_seg;
  logic [ADDR_W-1:0] img_addr;
  logic [DATA_W-1:0] img_data;
  logic              mosi_out;
  logic [1:0]        mode_out;
  logic              done_out;
  logic              busy;

  typedef struct {
    int               mode;
    logic [PKT_W-1:0] pkt;
  } exp_t;

  exp_t sb[$];

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en   = 1'b0;
  bit          chk_seg1 = 1'b0;
  int          run_len  = 0;
  int          run_mode = 0;
  int          cyc      = 0;
  int          t_first  = -1;
  int          t_stall  = -1;
  logic [31:0] run_bits = '0;

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .drive    (drive),
    .seg_en   (seg_en),
    .img_seg  (img_seg),
    .img_addr (img_addr),
    .img_data (img_data),
    .done_in  (done_in),
    .mosi_out (mosi_out),
    .mode_out (mode_out),
    .done_out (done_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input int s, input logic [ADDR_W-1:0] a);
    if (s == 0) return DATA_W'(a) + 8'h10;
    return ~DATA_W'(a);
  endfunction

  // Image store with one-cycle read latency
  always @(posedge clk) img_data <= rom_word(int'(img_seg), img_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seg(input int s);
    for (int a = 0; a < WORDS; a++) begin
      exp_t              e;
      logic [ADDR_W-1:0] av;
      logic [DATA_W-1:0] d;
      logic              fr;
      av = ADDR_W'(a);
      d  = rom_word(s, av);
`ifdef PROG_LOADER_PARITY_EN
      fr = ^{d, av};
`else
      fr = 1'b0;
`endif
      e.mode = s + 1;
      e.pkt  = {fr, d, av};
      sb.push_back(e);
    end
  endtask

  task automatic finish_run();
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_pkt", run_len, 0);
      return;
    end
    e = sb.pop_front();
    chk("pkt_len", run_len, PKT_W + 2);
    chk("pkt_setup_bits", run_bits[1:0], 0);
    chk("pkt_mode", run_mode, e.mode);
    chk("pkt_bits", run_bits[PKT_W+1:2], e.pkt);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done_out && n < limit) begin
      tick(1);
      n++;
    end
    chk("done_reached", done_out, 1);
  endtask

  // Packet monitor: a run of cycles under one load mode is SETUP0, SETUP1, then the packet bits
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || !mon_en) begin
        run_len = 0;
      end else begin
        if (busy && mode_out != 2'd0 && mode_out != 2'd3) begin
          if (t_first < 0) t_first = cyc;
          if (chk_seg1) chk("img_seg_fixed", img_seg, 1);
          if (run_len < 32) run_bits[run_len] = mosi_out;
          run_mode = int'(mode_out);
          run_len++;
        end else if (run_len != 0) begin
          finish_run();
          run_len = 0;
        end
        if (busy && mode_out == 2'd3 && t_stall < 0) t_stall = cyc;
      end
    end
  end

  initial begin
    rst     = 1'b1;
    drive   = 1'b0;
    done_in = 1'b0;
    seg_en  = '0;
    tick(2);
    chk("rst_mosi", mosi_out, 0);
    chk("rst_mode", mode_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_img_seg", img_seg, 0);
    chk("rst_img_addr", img_addr, 0);
    rst = 1'b0;
    tick(1);

    // Full load of both segments, then the FIN / done_in handshake
    seg_en = 2'b11;
    push_seg(0);
    push_seg(1);
    t_first = -1;
    t_stall = -1;
    mon_en  = 1'b1;
    drive   = 1'b1;
    tick(1);
    chk("first_setup0_mode", mode_out, 1);
    chk("first_setup0_busy", busy, 1);
    chk("first_setup0_seg", img_seg, 0);
    chk("first_setup0_addr", img_addr, 0);
    wait_done(700);
    chk("full_sb_empty", sb.size(), 0);
    chk("full_stall_cycle", t_stall - t_first, 512);
    chk("fin_busy", busy, 0);
    chk("fin_mode_run", mode_out, 3);
    tick(19);
    chk("fin_mode_before_done_in", mode_out, 3);
    done_in = 1'b1;
    tick(1);
    done_in = 1'b0;
    chk("mode_after_done_in", mode_out, 0);
    tick(3);
    chk("mode_stays_zero", mode_out, 0);
    chk("done_out_held", done_out, 1);
    drive = 1'b0;
    tick(1);
    chk("idle_done_out", done_out, 0);
    chk("idle_mode", mode_out, 0);

    // Only segment 1 enabled; mask changes after leaving IDLE must be ignored
    seg_en = 2'b10;
    push_seg(1);
    t_first  = -1;
    t_stall  = -1;
    chk_seg1 = 1'b1;
    drive    = 1'b1;
    tick(1);
    seg_en = 2'b11;
    chk("single_first_seg", img_seg, 1);
    chk("single_first_mode", mode_out, 2);
    wait_done(400);
    chk("single_sb_empty", sb.size(), 0);
    chk("single_stall_cycle", t_stall - t_first, 256);
    chk_seg1 = 1'b0;
    drive    = 1'b0;
    tick(1);

    // No segment enabled: straight through STALL to FIN
    seg_en = 2'b00;
    drive  = 1'b1;
    tick(1);
    chk("empty_stall_busy", busy, 1);
    chk("empty_stall_mode", mode_out, 3);
    chk("empty_stall_done", done_out, 0);
    tick(1);
    chk("empty_fin_done", done_out, 1);
    chk("empty_fin_busy", busy, 0);
    drive = 1'b0;
    tick(1);

    // Abort during bit 5 of word 3 in segment 0, then a clean restart
    mon_en = 1'b0;
    seg_en = 2'b11;
    drive  = 1'b1;
    tick(56);
    chk("abort_pre_mode", mode_out, 1);
    chk("abort_pre_addr", img_addr, 3);
    chk("abort_pre_busy", busy, 1);
    drive = 1'b0;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_mode", mode_out, 0);
    chk("abort_mosi", mosi_out, 0);
    chk("abort_done", done_out, 0);
    push_seg(0);
    push_seg(1);
    mon_en = 1'b1;
    drive  = 1'b1;
    tick(1);
    chk("restart_seg", img_seg, 0);
    chk("restart_addr", img_addr, 0);
    chk("restart_mode", mode_out, 1);
    wait_done(700);
    chk("restart_sb_empty", sb.size(), 0);
    drive = 1'b0;
    tick(1);

    // Asynchronous reset between clock edges in the middle of a packet
    mon_en = 1'b0;
    drive  = 1'b1;
    tick(20);
    chk("pre_rst_addr", img_addr, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mosi", mosi_out, 0);
    chk("async_rst_mode", mode_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done_out, 0);
    chk("async_rst_seg", img_seg, 0);
    chk("async_rst_addr", img_addr, 0);
    drive = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
